// File: rtl/switch_mcu_pkg.sv
// rtl/switch_mcu_pkg.sv - shared switch MCU core constants and register types
//
// Purpose: architectural widths and register-file types shared by the
// decoder, the execute units and the integer register file.
package switch_mcu_pkg;

  localparam int SWITCH_MCU_XLEN    = 32;
  localparam int SWITCH_MCU_REG_AW  = 5;
  localparam int SWITCH_MCU_REG_NUM = 32;

  localparam logic [SWITCH_MCU_REG_AW-1:0] SWITCH_MCU_ZERO_REG = 5'd0;

  typedef logic [SWITCH_MCU_REG_AW-1:0] reg_addr_t;
  typedef logic [SWITCH_MCU_XLEN-1:0]   reg_data_t;

endpackage

// File: rtl/switch_mcu_regfile_rd_port.sv
// rtl/switch_mcu_regfile_rd_port.sv - one registered read port of the integer register file
//
// Purpose: selects a register from the flattened storage array, forces x0
// to zero, optionally forwards a same-cycle write, and registers the result
// with a one-cycle valid strobe.
//
// Configuration macro: SWITCH_MCU_RF_BYPASS_EN
//   defined   - same-cycle read of the written address returns wdata_i
//   undefined - read returns the pre-write contents; write ports absent
//
// Ports:
//   clk_i, rst_i         core clock, asynchronous active-high reset
//   ren_i, raddr_i       read request and address
//   regs_i               flattened storage, entry g at [g*DATA_W +: DATA_W]
//   wen_i, waddr_i,      write request seen by the bypass mux
//   wdata_i              (bypass build only)
//   rdata_o, rvalid_o    registered read data and its one-cycle strobe
module switch_mcu_regfile_rd_port
  import switch_mcu_pkg::*;
#(
  parameter int DATA_W  = SWITCH_MCU_XLEN,
  parameter int ADDR_W  = SWITCH_MCU_REG_AW,
  parameter int REG_NUM = SWITCH_MCU_REG_NUM
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ren_i,
  input  logic [ADDR_W-1:0]         raddr_i,
  input  logic [REG_NUM*DATA_W-1:0] regs_i,
`ifdef SWITCH_MCU_RF_BYPASS_EN
  input  logic                      wen_i,
  input  logic [ADDR_W-1:0]         waddr_i,
  input  logic [DATA_W-1:0]         wdata_i,
`endif
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      rvalid_o
);

  logic [DATA_W-1:0] regs_arr [REG_NUM];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rvalid_d, rvalid_q;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_unpack
    assign regs_arr[g] = regs_i[g*DATA_W +: DATA_W];
  end

  // Data holds when no read is requested; the strobe follows the request.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ren_i;
    if (ren_i) begin
      if (raddr_i == ADDR_W'(SWITCH_MCU_ZERO_REG)) begin
        rdata_d = '0;
`ifdef SWITCH_MCU_RF_BYPASS_EN
      end else if (wen_i && (waddr_i == raddr_i)) begin
        // write-first: forward the value being committed this edge
        rdata_d = wdata_i;
`endif
      end else begin
        rdata_d = regs_arr[raddr_i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/switch_mcu_regfile.sv
// rtl/switch_mcu_regfile.sv - switch MCU integer register file, 2 read / 1 write
//
// Purpose: 32 x 32-bit architectural registers; x0 is not stored and reads
// as zero. Reads return one clock after the request with a valid strobe;
// writes commit on the next rising edge.
//
// Configuration macro: SWITCH_MCU_RF_BYPASS_EN
//   defined   - same-cycle read of the written address is write-first
//   undefined - same-cycle read of the written address is read-first
//
// Ports:
//   in_clk, in_rst                    core clock, asynchronous active-high reset
//   in_ren_1, in_raddr_1              read request, port 1
//   out_rdata_1, out_rvalid_1         read data and strobe, port 1
//   in_ren_2, in_raddr_2              read request, port 2
//   out_rdata_2, out_rvalid_2         read data and strobe, port 2
//   in_wen, in_waddr, in_wdata        write request
module switch_mcu_regfile
  import switch_mcu_pkg::*;
#(
  parameter int DATA_W  = SWITCH_MCU_XLEN,
  parameter int ADDR_W  = SWITCH_MCU_REG_AW,
  parameter int REG_NUM = SWITCH_MCU_REG_NUM
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ren_1,
  input  logic [ADDR_W-1:0] in_raddr_1,
  output logic [DATA_W-1:0] out_rdata_1,
  output logic              out_rvalid_1,
  input  logic              in_ren_2,
  input  logic [ADDR_W-1:0] in_raddr_2,
  output logic [DATA_W-1:0] out_rdata_2,
  output logic              out_rvalid_2,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata
);

  // Only x1..x(REG_NUM-1) exist as flops.
  logic [DATA_W-1:0]         regs_q [1:REG_NUM-1];
  logic [DATA_W-1:0]         regs_d [1:REG_NUM-1];
  logic [REG_NUM*DATA_W-1:0] regs_flat;

  // The loop starts at 1, so a write to x0 never matches and is dropped.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < REG_NUM; i++) begin
      if (in_wen && (in_waddr == ADDR_W'(i))) begin
        regs_d[i] = in_wdata;
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Slot 0 of the flattened view is a constant zero for x0.
  assign regs_flat[DATA_W-1:0] = '0;
  for (genvar g = 1; g < REG_NUM; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  switch_mcu_regfile_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_NUM (REG_NUM)
  ) u_rd_port_1 (
    .clk_i    (in_clk),
    .rst_i    (in_rst),
    .ren_i    (in_ren_1),
    .raddr_i  (in_raddr_1),
    .regs_i   (regs_flat),
`ifdef SWITCH_MCU_RF_BYPASS_EN
    .wen_i    (in_wen),
    .waddr_i  (in_waddr),
    .wdata_i  (in_wdata),
`endif
    .rdata_o  (out_rdata_1),
    .rvalid_o (out_rvalid_1)
  );

  switch_mcu_regfile_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_NUM (REG_NUM)
  ) u_rd_port_2 (
    .clk_i    (in_clk),
    .rst_i    (in_rst),
    .ren_i    (in_ren_2),
    .raddr_i  (in_raddr_2),
    .regs_i   (regs_flat),
`ifdef SWITCH_MCU_RF_BYPASS_EN
    .wen_i    (in_wen),
    .waddr_i  (in_waddr),
    .wdata_i  (in_wdata),
`endif
    .rdata_o  (out_rdata_2),
    .rvalid_o (out_rvalid_2)
  );

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// tb/tb_switch_mcu_regfile.sv - self-checking bench for switch_mcu_regfile
module tb_switch_mcu_regfile;

  logic        in_clk;
  logic        in_rst;
  logic        in_ren_1;
  logic [4:0]  in_raddr_1;
  logic [31:0] out_rdata_1;
  logic        out_rvalid_1;
  logic        in_ren_2;
  logic [4:0]  in_raddr_2;
  logic [31:0] out_rdata_2;
  logic        out_rvalid_2;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;

  int checks = 0;
  int errors = 0;

`ifdef SWITCH_MCU_RF_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h0000_0022;
`else
  localparam logic [31:0] COLL_EXP = 32'h0000_0011;
`endif

  switch_mcu_regfile dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_ren_1     (in_ren_1),
    .in_raddr_1   (in_raddr_1),
    .out_rdata_1  (out_rdata_1),
    .out_rvalid_1 (out_rvalid_1),
    .in_ren_2     (in_ren_2),
    .in_raddr_2   (in_raddr_2),
    .out_rdata_2  (out_rdata_2),
    .out_rvalid_2 (out_rvalid_2),
    .in_wen       (in_wen),
    .in_waddr     (in_waddr),
    .in_wdata     (in_wdata)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // One clock with the given requests, then all requests drop.
  task automatic drive_cycle(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                             input logic ren1, input logic [4:0] a1,
                             input logic ren2, input logic [4:0] a2);
    in_wen = wen; in_waddr = waddr; in_wdata = wdata;
    in_ren_1 = ren1; in_raddr_1 = a1;
    in_ren_2 = ren2; in_raddr_2 = a2;
    tick();
    in_wen = 1'b0; in_ren_1 = 1'b0; in_ren_2 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_rvalid_1 !== 1'b0) begin errors++; $display("FAIL rst_rvalid_1: got %b expected 0", out_rvalid_1); end
    checks++; if (out_rvalid_2 !== 1'b0) begin errors++; $display("FAIL rst_rvalid_2: got %b expected 0", out_rvalid_2); end
    checks++; if (out_rdata_1 !== 32'h0) begin errors++; $display("FAIL rst_rdata_1: got %h expected 0", out_rdata_1); end
    checks++; if (out_rdata_2 !== 32'h0) begin errors++; $display("FAIL rst_rdata_2: got %h expected 0", out_rdata_2); end
    in_ren_1 = 1'b1; in_raddr_1 = 5'd0; in_ren_2 = 1'b1; in_raddr_2 = 5'd0;
    tick();
    checks++; if (out_rvalid_1 !== 1'b0 || out_rvalid_2 !== 1'b0) begin errors++; $display("FAIL rst_ignore_req: got %b%b expected 00", out_rvalid_1, out_rvalid_2); end
    tick();
    in_rst = 1'b0; in_ren_1 = 1'b0; in_ren_2 = 1'b0;
    tick();

    drive_cycle(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    checks++; if (out_rdata_1 !== 32'h1234_5678) begin errors++; $display("FAIL pre_rst_x5: got %h expected 12345678", out_rdata_1); end

    // Reset mid-access: read and write requests pending when reset rises.
    in_ren_1 = 1'b1; in_raddr_1 = 5'd5; in_ren_2 = 1'b1; in_raddr_2 = 5'd5;
    in_wen = 1'b1; in_waddr = 5'd6; in_wdata = 32'hCAFE_0006;
    in_rst = 1'b1;
    #1;
    checks++; if (out_rvalid_1 !== 1'b0 || out_rvalid_2 !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b%b expected 00", out_rvalid_1, out_rvalid_2); end
    checks++; if (out_rdata_1 !== 32'h0 || out_rdata_2 !== 32'h0) begin errors++; $display("FAIL rst_async_data: got %h %h expected 0 0", out_rdata_1, out_rdata_2); end
    tick();
    checks++; if (out_rvalid_1 !== 1'b0 || out_rvalid_2 !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b%b expected 00", out_rvalid_1, out_rvalid_2); end
    in_rst = 1'b0; in_ren_1 = 1'b0; in_ren_2 = 1'b0; in_wen = 1'b0;
    tick();
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    checks++; if (out_rdata_1 !== 32'h0) begin errors++; $display("FAIL post_rst_x5: got %h expected 0", out_rdata_1); end
    checks++; if (out_rdata_2 !== 32'h0) begin errors++; $display("FAIL rst_abort_write_x6: got %h expected 0", out_rdata_2); end
    checks++; if (out_rvalid_1 !== 1'b1 || out_rvalid_2 !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b%b expected 11", out_rvalid_1, out_rvalid_2); end
  endtask

  task automatic test_basic();
    drive_cycle(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    checks++; if (out_rdata_1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rdata_1: got %h expected deadbeef", out_rdata_1); end
    checks++; if (out_rdata_2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rdata_2: got %h expected deadbeef", out_rdata_2); end
    checks++; if (out_rvalid_1 !== 1'b1 || out_rvalid_2 !== 1'b1) begin errors++; $display("FAIL basic_rvalid: got %b%b expected 11", out_rvalid_1, out_rvalid_2); end
    tick();
    checks++; if (out_rvalid_1 !== 1'b0 || out_rvalid_2 !== 1'b0) begin errors++; $display("FAIL basic_strobe_len: got %b%b expected 00", out_rvalid_1, out_rvalid_2); end
    checks++; if (out_rdata_1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_hold: got %h expected deadbeef", out_rdata_1); end
  endtask

  task automatic test_x0();
    drive_cycle(1'b1, 5'd8, 32'h0BAD_F00D, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd8);
    checks++; if (out_rdata_1 !== 32'h0) begin errors++; $display("FAIL x0_read: got %h expected 0", out_rdata_1); end
    checks++; if (out_rdata_2 !== 32'h0BAD_F00D) begin errors++; $display("FAIL x0_no_side_effect: got %h expected 0badf00d", out_rdata_2); end
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    checks++; if (out_rdata_1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_x7_intact: got %h expected deadbeef", out_rdata_1); end
    // x0 read racing an x0 write stays zero in both builds
    drive_cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    checks++; if (out_rdata_1 !== 32'h0 || out_rdata_2 !== 32'h0) begin errors++; $display("FAIL x0_collision: got %h %h expected 0 0", out_rdata_1, out_rdata_2); end
    // a write with wen low changes nothing
    drive_cycle(1'b0, 5'd8, 32'h5555_5555, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b0, 5'd0);
    checks++; if (out_rdata_1 !== 32'h0BAD_F00D) begin errors++; $display("FAIL wen_low_ignored: got %h expected 0badf00d", out_rdata_1); end
  endtask

  task automatic test_collision();
    drive_cycle(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 1'b1, 5'd3);
    checks++; if (out_rdata_2 !== COLL_EXP) begin errors++; $display("FAIL collision_same_cycle: got %h expected %h", out_rdata_2, COLL_EXP); end
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3);
    checks++; if (out_rdata_2 !== 32'h22) begin errors++; $display("FAIL collision_next_read: got %h expected 22", out_rdata_2); end
  endtask

  task automatic test_hold();
    drive_cycle(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
    checks++; if (out_rdata_1 !== 32'hA5A5_A5A5 || out_rvalid_1 !== 1'b1) begin errors++; $display("FAIL hold_first_read: got %h/%b expected a5a5a5a5/1", out_rdata_1, out_rvalid_1); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 5'd9, 32'h0, 1'b0, 5'd9, 1'b0, 5'd0);
      checks++; if (out_rdata_1 !== 32'hA5A5_A5A5 || out_rvalid_1 !== 1'b0) begin errors++; $display("FAIL hold_cycle_%0d: got %h/%b expected a5a5a5a5/0", i, out_rdata_1, out_rvalid_1); end
    end
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
    checks++; if (out_rdata_1 !== 32'h0) begin errors++; $display("FAIL hold_after_write: got %h expected 0", out_rdata_1); end
  endtask

  task automatic test_exec_seq();
    logic [31:0] a_tab   [3];
    logic [31:0] b_tab   [3];
    logic [1:0]  op_tab  [3];
    logic [31:0] exp_tab [3];
    logic [31:0] ra, rb, res;
    a_tab = '{32'd5, 32'd5, 32'h8000_0000};
    b_tab = '{32'd3, 32'd3, 32'd4};
    op_tab = '{2'd0, 2'd1, 2'd2};
    exp_tab = '{32'd8, 32'd2, 32'hF800_0000};
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 5'd1, a_tab[k], 1'b0, 5'd0, 1'b0, 5'd0);
      drive_cycle(1'b1, 5'd2, b_tab[k], 1'b0, 5'd0, 1'b0, 5'd0);
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
      ra = out_rdata_1;
      rb = out_rdata_2;
      case (op_tab[k])
        2'd0:    res = ra + rb;
        2'd1:    res = ra - rb;
        default: res = $unsigned($signed(ra) >>> rb[4:0]);
      endcase
      drive_cycle(1'b1, 5'd4, res, 1'b0, 5'd0, 1'b0, 5'd0);
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0);
      checks++; if (out_rdata_1 !== exp_tab[k]) begin errors++; $display("FAIL exec_op%0d_x4: got %h expected %h", k, out_rdata_1, exp_tab[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    v = '{32'h1000_000A, 32'h2000_000B, 32'h3000_000C, 32'h4000_000D};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 5'(10 + i), v[i], 1'b0, 5'd0, 1'b0, 5'd0);
    end
    for (int i = 0; i < 4; i++) begin
      in_ren_1 = 1'b1; in_raddr_1 = 5'(10 + i);
      in_ren_2 = 1'b1; in_raddr_2 = 5'(13 - i);
      tick();
      checks++; if (out_rdata_1 !== v[i] || out_rvalid_1 !== 1'b1) begin errors++; $display("FAIL b2b_p1_%0d: got %h/%b expected %h/1", i, out_rdata_1, out_rvalid_1, v[i]); end
      checks++; if (out_rdata_2 !== v[3-i] || out_rvalid_2 !== 1'b1) begin errors++; $display("FAIL b2b_p2_%0d: got %h/%b expected %h/1", i, out_rdata_2, out_rvalid_2, v[3-i]); end
    end
    in_ren_1 = 1'b0; in_ren_2 = 1'b0;
    // write at edge N, read requested at edge N+1 sees the new value
    drive_cycle(1'b1, 5'd31, 32'h7777_1F1F, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd31);
    checks++; if (out_rdata_2 !== 32'h7777_1F1F) begin errors++; $display("FAIL write_latency_x31: got %h expected 77771f1f", out_rdata_2); end
  endtask

  initial begin
    in_rst = 1'b1;
    in_ren_1 = 1'b0; in_raddr_1 = 5'd0;
    in_ren_2 = 1'b0; in_raddr_2 = 5'd0;
    in_wen = 1'b0; in_waddr = 5'd0; in_wdata = 32'h0;
    test_reset();
    test_basic();
    test_x0();
    test_collision();
    test_hold();
    test_exec_seq();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_mcu_regfile.md
# switch_mcu_regfile

Integer register file of the switch MCU core: 32 × 32-bit architectural registers with two read ports and one write port. It is the responder for the register-access handshake driven by the execute units. It accepts registered read requests (`ren`/`raddr`) and returns data one clock later with a valid strobe. It commits write requests (`wen`/`waddr`/`wdata`) on the next edge. Register x0 is hardwired to zero.

## Interface
Parameters:
- `DATA_W`, 32: register width
- `ADDR_W`, 5: register address width
- `REG_NUM`, 32: number of registers; must equal 2^`ADDR_W`

Ports:
- `in_clk`  in  1  core clock; single clock domain
- `in_rst`  in  1  asynchronous, active-high reset
- `in_ren_1`  in  1  read request, port 1
- `in_raddr_1`  in  `ADDR_W`  read address, port 1
- `out_rdata_1`  out  `DATA_W`  read data, port 1
- `out_rvalid_1`  out  1  one-cycle strobe: `out_rdata_1` is fresh
- `in_ren_2`  in  1  read request, port 2
- `in_raddr_2`  in  `ADDR_W`  read address, port 2
- `out_rdata_2`  out  `DATA_W`  read data, port 2
- `out_rvalid_2`  out  1  one-cycle strobe: `out_rdata_2` is fresh
- `in_wen`  in  1  write request
- `in_waddr`  in  `ADDR_W`  write address
- `in_wdata`  in  `DATA_W`  write data

## Operation
- Storage: registers x1..x31 are flops; x0 is not stored and always reads as 0.
- Write:
  - If `in_wen`=1 and `in_waddr`≠0, `in_wdata` is committed at the rising edge.
  - A write with `in_waddr`=0 is silently dropped.
  - A write with `in_wen`=0 has no effect, whatever `in_waddr`/`in_wdata` carry.
- Read:
  - If `in_ren_n`=1, the register at `in_raddr_n` is captured into `out_rdata_n` at the edge and `out_rvalid_n` is set for one cycle.
  - If `in_ren_n`=0, `out_rdata_n` holds its last value and `out_rvalid_n`=0.
- The two read ports are fully independent. They may address the same register in the same cycle, and both return identical data.
- Read/write collision: both ports may read the address being written in the same cycle. The behaviour is set by the Configuration macro.
- Reset:
  - While `in_rst`=1: all registers clear to 0, `out_rdata_1`/`out_rdata_2` are 0, and `out_rvalid_1`/`out_rvalid_2` are 0.
  - Requests present during reset are ignored.
  - Reset asserting mid-access aborts the access: no write commits and no valid strobe is issued.
- Width rules: no arithmetic is performed. Address bits beyond `REG_NUM`-1 cannot occur, because `REG_NUM` = 2^`ADDR_W`.

## Timing
- Read latency is 1 cycle. With request at edge N, `out_rdata_n`/`out_rvalid_n` are valid from edge N+1 and remain valid until edge N+2.
- Write latency is 1 cycle. Data written at edge N is readable by a request sampled at edge N+1, which returns data at N+2.
- Back-to-back reads on every cycle are supported. Throughput is one read per port per cycle, plus one write per cycle.
- Fit with the R-type execute sequence:
  - The execute unit registers the read request at cycle_cnt=1, so it is presented during cycle 2.
  - The register file returns data from cycle 3.
  - The execute unit samples the data at cycle_cnt=4, and its write arrives one cycle later.
- No backpressure. The register file always accepts requests; there is no ready signal.

## Configuration
- `SWITCH_MCU_RF_BYPASS_EN`
  - Defined: on a same-cycle read of the address being written (`in_wen`=1, `in_waddr`=`in_raddr_n`≠0), `out_rdata_n` returns `in_wdata` (write-first).
  - Undefined: that read returns the pre-write register contents (read-first); the new value is visible from the next read.
- A read of x0 returns 0 in both builds.

## Structure
- Shared package `switch_mcu_pkg` holds:
  - `SWITCH_MCU_XLEN` (32), `SWITCH_MCU_REG_AW` (5), `SWITCH_MCU_REG_NUM` (32), `SWITCH_MCU_ZERO_REG` (5'd0)
  - typedefs `reg_addr_t` and `reg_data_t`, shared with the decoder and execute units
- One sub-module, `switch_mcu_regfile_rd_port`, instantiated twice. It contains the x0 check, the bypass mux, the output data register and the valid strobe. It takes the storage array as a flattened input.

## Test plan
- Reset: assert `in_rst` after writing x5=0x1234_5678, then release; read x5 on port 1 → `out_rdata_1`=0. During reset, `out_rvalid_1`=`out_rvalid_2`=0 and both data outputs are 0.
- Basic write/read: write x7=0xDEAD_BEEF at edge N; request x7 on both ports at edge N+1 → both `out_rdata`=0xDEAD_BEEF with `out_rvalid` high at N+2 for exactly one cycle.
- x0: write x0=0xFFFF_FFFF, then read x0 → 0. Confirm that no stored register changed.
- Collision: x3=0x11, then in one cycle write x3=0x22 and read x3 on port 2. Expect 0x22 with `SWITCH_MCU_RF_BYPASS_EN` defined and 0x11 without; the next read returns 0x22 in both builds.
- Hold: read x9=0xA5A5_A5A5, then deassert `in_ren_1` for 3 cycles while writing x9=0 → `out_rdata_1` stays 0xA5A5_A5A5 and `out_rvalid_1`=0.
- Sequence with the execute unit: x1=5, x2=3, add x4 → x4 reads 8 at the next access. For sub, x4=2; for sra with x1=0x8000_0000 and x2=4, x4=0xF800_0000.
